pf_diff_tx_serializer: RTL
==========================

// Module: pf_diff_tx_serializer
// PURPOSE
//  Transmit-side counterpart of the differential input buffer path: accepts parallel words on a
//  valid/ready handshake and shifts them out as an asynchronous-framed serial stream on a
//  complementary pad pair (PADOP/PADON) feeding a differential PF_IO output.
//  Sits between fabric logic and the output I/O macro; the far end recovers the stream via the LVDS input buffer.
// PARAMETERS
//  DATA_W        8   data bits per frame (1..16), sent LSB first
//  CLKS_PER_BIT  16  CLK cycles per serial bit (>=2)
//  STOP_BITS     1   stop bits per frame (1 or 2)
//  PARITY_ODD    0   0 = even parity, 1 = odd parity (used only with DIFF_TX_PARITY_EN)
// PORTS
//  CLK       in   1       system clock, all logic rising-edge
//  RESETN    in   1       reset: asynchronous assert, active-low
//  TX_DATA   in   DATA_W  word to send, sampled on accept
//  TX_VALID  in   1       TX_DATA valid
//  TX_READY  out  1       block can accept a word this cycle
//  TX_BUSY   out  1       frame in progress (START..STOP)
//  PADOP     out  1       serial line, true leg (idle 1)
//  PADON     out  1       serial line, complement leg (always ~PADOP)
//  OE        out  1       output enable to pad macro E input
// BEHAVIOUR
//  Reset (RESETN low, immediate): state IDLE, PADOP=1, PADON=0, TX_READY=1, TX_BUSY=0, OE=0,
//   counters and shift register cleared. OE rises on first CLK edge after RESETN release, then stays 1.
//  All outputs registered; PADON is a separate flop loaded with the inverse of PADOP's next value.
//  FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//   IDLE: TX_READY=1, line=1. Accept when TX_VALID&&TX_READY&&OE: latch TX_DATA, go START next cycle.
//   START: line=0 for CLKS_PER_BIT cycles.
//   DATA: DATA_W bits, shift register LSB first, each CLKS_PER_BIT cycles.
//   PARITY: one bit (see CONFIGURATION).
//   STOP: line=1 for STOP_BITS*CLKS_PER_BIT cycles, then IDLE.
//  TX_READY=1 only in IDLE; TX_BUSY=1 in every non-IDLE state. Accept-to-start-bit latency: 1 cycle.
//  Frame length F = (1+DATA_W+P+STOP_BITS)*CLKS_PER_BIT cycles (P=1 if parity built, else 0);
//   with TX_VALID held high, accepts repeat every F+1 cycles (one IDLE cycle between frames).
//  Bit timer counts CLKS_PER_BIT-1 down to 0, reloads on every bit boundary; bit counter
//   width $clog2(DATA_W+1); no wrap beyond DATA_W.
//  TX_VALID while busy ignored (not queued); TX_DATA changes mid-frame have no effect.
//  Accept blocked while OE=0 (first cycle after reset).
//  RESETN asserted mid-frame: frame truncated, line returns to 1 immediately; no resume.
// CONFIGURATION
//  Macro DIFF_TX_PARITY_EN:
//   defined: PARITY state inserted after DATA; bit = ^data for even, ~^data for odd (PARITY_ODD).
//   undefined: no PARITY state, no parity logic; PARITY_ODD ignored; P=0 in frame length.
// TESTING (DATA_W=8, CLKS_PER_BIT=4, STOP_BITS=1 unless stated)
//  1 Reset: RESETN low mid-run -> PADOP=1, PADON=0, TX_READY=1, TX_BUSY=0, OE=0 same cycle; OE=1 one edge after release.
//  2 No parity, TX_DATA=0xA5 accepted -> PADOP = 0,1,0,1,0,0,1,0,1,1 each 4 cycles (40 total),
//    PADON complement every cycle, TX_BUSY high exactly 40 cycles.
//  3 Parity even, 0xA5 -> parity bit 0, frame 44 cycles; PARITY_ODD=1 -> parity bit 1; 0x01 even -> 1.
//  4 Back-to-back: TX_VALID held, 0x00 then 0xFF -> second start bit begins 41 cycles after first
//    (no parity); TX_READY high for exactly 1 cycle between frames.
//  5 Busy interference: pulse TX_VALID with 0x3C and change TX_DATA during frame of 0x81 -> 0x81 sent
//    intact, 0x3C dropped; STOP_BITS=2 -> stop segment 8 cycles.
//  6 Reset during DATA bit 3 -> line 1 immediately; after release, next word 0x5A sent as full clean frame.

Source files
------------

// File: rtl/pf_diff_tx_serializer.sv
// Parallel-to-serial framed transmitter driving a complementary pad pair (PADOP/PADON).
// Optional parity bit enabled by defining DIFF_TX_PARITY_EN.
module pf_diff_tx_serializer #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic              CLK,
    input  logic              RESETN,
    input  logic [DATA_W-1:0] TX_DATA,
    input  logic              TX_VALID,
    output logic              TX_READY,
    output logic              TX_BUSY,
    output logic              PADOP,
    output logic              PADON,
    output logic              OE
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_W + 1);
    localparam logic [TW-1:0] RELOAD = TW'(CLKS_PER_BIT - 1);

    generate
        if (DATA_W < 1 || DATA_W > 16 || CLKS_PER_BIT < 2 ||
            STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_param
            $error("pf_diff_tx_serializer: illegal parameter value");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef DIFF_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t            state_q, state_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              padop_q, padon_q, ready_q, busy_q, oe_q;
    logic              line_d, accept, tick;
`ifdef DIFF_TX_PARITY_EN
    logic              par_q, par_d;
`endif

    assign accept = (state_q == S_IDLE) && TX_VALID && ready_q && oe_q;
    assign tick   = (timer_q == '0);

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
`ifdef DIFF_TX_PARITY_EN
        par_d   = par_q;
`endif
        if (state_q != S_IDLE)
            timer_d = tick ? RELOAD : timer_q - 1'b1;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_START;
                    shreg_d = TX_DATA;
                    timer_d = RELOAD;
                    bit_d   = '0;
`ifdef DIFF_TX_PARITY_EN
                    par_d   = (^TX_DATA) ^ (PARITY_ODD != 0);
`endif
                end
            end
            S_START: begin
                if (tick) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                end
            end
            S_DATA: begin
                // Bit 0 is already on the line when DATA is entered; shift only between bits.
                if (tick) begin
                    if (bit_q == BW'(DATA_W - 1)) begin
`ifdef DIFF_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                        bit_d   = '0;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shreg_d = shreg_q >> 1;
                    end
                end
            end
`ifdef DIFF_TX_PARITY_EN
            S_PARITY: begin
                if (tick) state_d = S_STOP;
            end
`endif
            S_STOP: begin
                // Bit counter is reused to count stop bits.
                if (tick) begin
                    if (bit_q == BW'(STOP_BITS - 1)) state_d = S_IDLE;
                    else                             bit_d   = bit_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        line_d = 1'b1;
        case (state_d)
            S_START:  line_d = 1'b0;
            S_DATA:   line_d = shreg_d[0];
`ifdef DIFF_TX_PARITY_EN
            S_PARITY: line_d = par_d;
`endif
            default:  line_d = 1'b1;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            padop_q <= 1'b1;
            padon_q <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            oe_q    <= 1'b0;
`ifdef DIFF_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            padop_q <= line_d;
            padon_q <= ~line_d;
            ready_q <= (state_d == S_IDLE);
            busy_q  <= (state_d != S_IDLE);
            oe_q    <= 1'b1;
`ifdef DIFF_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign PADOP    = padop_q;
    assign PADON    = padon_q;
    assign TX_READY = ready_q;
    assign TX_BUSY  = busy_q;
    assign OE       = oe_q;

endmodule
